// File: rtl/dob_serializer_if.sv
// Word-side handshake and serial output bundle of the DOB serializer.
// The upstream word source uses the master modport and the serializer uses the slave modport.
interface dob_serializer_if #(
    parameter int WORD_W = 10,
    parameter int CNT_W  = 16
);
    logic [WORD_W-1:0] data_in;
    logic              data_valid;
    logic              data_ack;
    logic              sync_done;
    logic              ser_out;
    logic              frame_strobe;
    logic [CNT_W-1:0]  word_count;

    modport master (
        output data_in,
        output data_valid,
        input  data_ack,
        input  sync_done,
        input  ser_out,
        input  frame_strobe,
        input  word_count
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ack,
        output sync_done,
        output ser_out,
        output frame_strobe,
        output word_count
    );
endinterface

// File: rtl/dob_serializer.sv
// DOB output serializer: sends SYNC_FRAMES comma words after every reset, then
// shifts out handshaked 8b10b words MSB first, with idle words filling any gaps.
module dob_serializer #(
    parameter int                 WORD_W      = 10,
    parameter int                 SYNC_FRAMES = 32,
    parameter logic [WORD_W-1:0]  IDLE_WORD   = 10'b0011111010,
    parameter int                 CNT_W       = 16
) (
    input  logic           clock,
    input  logic           rst_n,
    dob_serializer_if.slave bus
);
    localparam int BC_W = $clog2(WORD_W);
    localparam int FC_W = $clog2(SYNC_FRAMES + 1);
    localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(WORD_W - 1);
    localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(SYNC_FRAMES - 1);

    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    logic [WORD_W-1:0] shift_q,     shift_d;
    logic [BC_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic              ack_q,       ack_d;
    logic              strobe_q,    strobe_d;
    logic              sync_q,      sync_d;
    logic [CNT_W-1:0]  count_q,     count_d;

    // Next-state logic: a load edge every WORD_W cycles, shifting in between.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        ack_d       = 1'b0;
        strobe_d    = 1'b0;
        sync_d      = sync_q;
        count_d     = count_q;
        if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = {BC_W{1'b0}};
            strobe_d  = 1'b1;
            case (state_q)
                ST_SYNC: begin
                    // data_valid is deliberately ignored until the receiver has had its commas.
                    shift_d     = IDLE_WORD;
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                    if (frame_cnt_q == FRAME_LAST) begin
                        state_d = ST_RUN;
                        sync_d  = 1'b1;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                ST_RUN: begin
                    if (bus.data_valid) begin
                        shift_d = bus.data_in;
                        ack_d   = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        shift_d = IDLE_WORD;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                    shift_d = IDLE_WORD;
                end
            endcase
        end else begin
            shift_d   = {shift_q[WORD_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
    end

    // State and output registers; reset leaves the counter primed so the first edge loads.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SYNC;
            shift_q     <= {WORD_W{1'b0}};
            bit_cnt_q   <= BIT_LAST;
            frame_cnt_q <= {FC_W{1'b0}};
            ack_q       <= 1'b0;
            strobe_q    <= 1'b0;
            sync_q      <= 1'b0;
            count_q     <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            ack_q       <= ack_d;
            strobe_q    <= strobe_d;
            sync_q      <= sync_d;
            count_q     <= count_d;
        end
    end

    assign bus.ser_out      = shift_q[WORD_W-1];
    assign bus.data_ack     = ack_q;
    assign bus.frame_strobe = strobe_q;
    assign bus.sync_done    = sync_q;
    assign bus.word_count   = count_q;
endmodule

// File: tb/tb_dob_serializer.sv
// Randomized bench for dob_serializer, checked against a stream-level reference model
// (load number and bit position derived from the edge count since reset release).
module tb_dob_serializer;
    localparam int          W    = 10;
    localparam int          SF   = 4;
    localparam int          CW   = 16;
    localparam logic [W-1:0] IDLE = 10'b0011111010;

    logic clock = 1'b0;
    logic rst_n;
    logic rst2_n;

    dob_serializer_if #(.WORD_W(W), .CNT_W(CW)) bus ();
    dob_serializer_if #(.WORD_W(2), .CNT_W(4))  bus2 ();

    dob_serializer #(.WORD_W(W), .SYNC_FRAMES(SF), .IDLE_WORD(IDLE), .CNT_W(CW)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dob_serializer #(.WORD_W(2), .SYNC_FRAMES(1), .IDLE_WORD(2'b01), .CNT_W(4)) dut2 (
        .clock (clock),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: edges since release decide load number and bit position.
    int            t_m;
    logic [W-1:0]  cur_m;
    bit            data_m;
    logic [CW-1:0] cnt_m;
    bit            e_ser, e_fs, e_ack, e_sync;
    logic [W-1:0]  pend_q[$];
    bit            rand_mode;
    int            acks_seen;
    int            first_ack_t;

    task automatic model_reset();
        t_m = 0; cur_m = '0; data_m = 1'b0; cnt_m = '0;
        e_ser = 1'b0; e_fs = 1'b0; e_ack = 1'b0; e_sync = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [W-1:0] d);
        int pos;
        int k;
        t_m++;
        pos = (t_m - 1) % W;
        k   = (t_m - 1) / W + 1;
        if (pos == 0) begin
            if (k > SF && v) begin
                cur_m = d; data_m = 1'b1; cnt_m = cnt_m + 16'd1;
            end else begin
                cur_m = IDLE; data_m = 1'b0;
            end
        end
        e_ser  = cur_m[W-1-pos];
        e_fs   = (pos == 0);
        e_ack  = (pos == 0) && data_m;
        e_sync = (k >= SF);
    endtask

    task automatic check_outputs();
        chk("ser_out",      {31'd0, bus.ser_out},      {31'd0, e_ser});
        chk("frame_strobe", {31'd0, bus.frame_strobe}, {31'd0, e_fs});
        chk("data_ack",     {31'd0, bus.data_ack},     {31'd0, e_ack});
        chk("sync_done",    {31'd0, bus.sync_done},    {31'd0, e_sync});
        chk("word_count",   {16'd0, bus.word_count},   {16'd0, cnt_m});
    endtask

    task automatic feed();
        if (!bus.data_valid) begin
            if (pend_q.size() > 0) begin
                bus.data_in    = pend_q.pop_front();
                bus.data_valid = 1'b1;
            end else if (rand_mode && $urandom_range(0, 3) == 0) begin
                bus.data_in    = W'($urandom);
                bus.data_valid = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        bit           v;
        logic [W-1:0] d;
        v = bus.data_valid;
        d = bus.data_in;
        @(posedge clock);
        #1;
        model_edge(v, d);
        check_outputs();
        if (bus.data_ack) begin
            acks_seen++;
            if (first_ack_t == 0) first_ack_t = t_m;
        end
        if (e_ack) bus.data_valid = 1'b0;
        feed();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3*W-1:0] stream;
        int             raise_t;
        int             ack_t;
        int             t2;
        int             k2;
        int             pos2;

        rst_n = 1'b0; rst2_n = 1'b0; rand_mode = 1'b0;
        bus.data_valid = 1'b1; bus.data_in = 10'h2AA;
        bus2.data_valid = 1'b0; bus2.data_in = 2'b00;
        acks_seen = 0; first_ack_t = 0;
        model_reset();

        // Reset held with valid high: everything stays cleared.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ser_out",   {31'd0, bus.ser_out},      32'd0);
        chk("rst_sync_done", {31'd0, bus.sync_done},    32'd0);
        chk("rst_strobe",    {31'd0, bus.frame_strobe}, 32'd0);
        chk("rst_ack",       {31'd0, bus.data_ack},     32'd0);
        chk("rst_count",     {16'd0, bus.word_count},   32'd0);
        @(negedge clock);
        rst_n = 1'b1;

        // Sync sequence followed by the first word (0x2AA).
        repeat (50) cycle();
        chk("first_ack_edge",   first_ack_t,                  32'd41);
        chk("first_word_count", {16'd0, bus.word_count},      32'd1);
        chk("first_acks",       acks_seen,                    32'd1);

        // Back-to-back words then an idle gap.
        acks_seen = 0;
        pend_q.push_back(10'h3FF);
        pend_q.push_back(10'h001);
        feed();
        for (int i = 0; i < 3 * W; i++) begin
            cycle();
            stream = {stream[3*W-2:0], bus.ser_out};
        end
        chk("b2b_stream", {2'd0, stream}, {2'd0, 10'h3FF, 10'h001, IDLE});
        chk("b2b_acks",   acks_seen,              32'd2);
        chk("b2b_count",  {16'd0, bus.word_count}, 32'd3);

        // Late valid: raised three edges after a load edge.
        while (t_m < 3 * W + 50 + 4) cycle();
        bus.data_in = W'($urandom); bus.data_valid = 1'b1;
        raise_t = t_m; ack_t = -1;
        for (int i = 0; i < 20 && ack_t < 0; i++) begin
            cycle();
            if (bus.data_ack) ack_t = t_m;
        end
        chk("late_ack_delay", ack_t - raise_t, 32'd7);

        // Reset in the middle of a data word.
        pend_q.push_back(W'($urandom));
        feed();
        ack_t = -1;
        for (int i = 0; i < 3 * W && ack_t < 0; i++) begin
            cycle();
            if (bus.data_ack) ack_t = t_m;
        end
        repeat (5) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midword_ser_out",   {31'd0, bus.ser_out},    32'd0);
        chk("midword_sync_done", {31'd0, bus.sync_done},  32'd0);
        chk("midword_count",     {16'd0, bus.word_count}, 32'd0);
        model_reset();
        bus.data_in = W'($urandom); bus.data_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        acks_seen = 0; first_ack_t = 0;
        repeat (SF * W + 12) cycle();
        chk("resync_first_ack", first_ack_t, SF * W + 1);

        // Randomized traffic.
        rand_mode = 1'b1;
        repeat (400) cycle();
        rand_mode = 1'b0;

        // Counter wrap on a narrow instance with valid always high.
        bus2.data_valid = 1'b1; bus2.data_in = 2'($urandom);
        @(negedge clock);
        rst2_n = 1'b1;
        for (t2 = 1; t2 <= 40; t2++) begin
            @(posedge clock);
            #1;
            k2   = (t2 - 1) / 2 + 1;
            pos2 = (t2 - 1) % 2;
            chk("wrap_count", {28'd0, bus2.word_count}, (k2 > 1) ? ((k2 - 1) % 16) : 0);
            chk("wrap_ack",   {31'd0, bus2.data_ack},   (pos2 == 0 && k2 >= 2) ? 32'd1 : 32'd0);
            chk("wrap_sync",  {31'd0, bus2.sync_done},  32'd1);
            if (t2 == 33) chk("wrap_zero", {28'd0, bus2.word_count}, 32'd0);
            if (pos2 == 0 && k2 >= 2) bus2.data_in = 2'($urandom);
        end
        chk("wrap_final", {28'd0, bus2.word_count}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
